// File: rtl/anemo_pkg.sv
// Shared state encoding, data constants and gate-window sizing helpers for the anemometer meter.
package anemo_pkg;

  localparam int ANEMO_DATA_W = 8;
  localparam int ANEMO_SAT    = 255;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_DONE    = 2'd2
  } anemo_state_t;

  function automatic int gate_cycles(input int clk_freq_hz, input int gate_ms);
    return (clk_freq_hz / 1000) * gate_ms;
  endfunction

  function automatic int gate_cnt_w(input int clk_freq_hz, input int gate_ms);
    return $clog2(gate_cycles(clk_freq_hz, gate_ms));
  endfunction

endpackage

// File: rtl/anemo_edge_detect.sv
// Synchronises the raw anemometer pulse and emits a one-cycle rising-edge pulse 3 cycles later
// (3+FILTER_LEN when ANEMO_GLITCH_FILTER_EN adds the hold-time filter); no backpressure.
module anemo_edge_detect
`ifdef ANEMO_GLITCH_FILTER_EN
#(
  parameter int FILTER_LEN = 4
)
`endif
(
  input  logic clk,
  input  logic reset_n,
  input  logic raw_pulse,
  output logic rise_pulse
);

  logic sync_q0;
  logic sync_q1;
  logic level;
  logic level_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q0 <= 1'b0;
      sync_q1 <= 1'b0;
    end else begin
      sync_q0 <= raw_pulse;
      sync_q1 <= sync_q0;
    end
  end

`ifdef ANEMO_GLITCH_FILTER_EN
  localparam int FLT_W = $clog2(FILTER_LEN + 1);

  logic [FLT_W-1:0] flt_cnt;
  logic             flt_level;

  // The run counter restarts whenever the input agrees with the filtered level again.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flt_cnt   <= '0;
      flt_level <= 1'b0;
    end else if (sync_q1 == flt_level) begin
      flt_cnt <= '0;
    end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
      flt_cnt   <= '0;
      flt_level <= sync_q1;
    end else begin
      flt_cnt <= flt_cnt + FLT_W'(1);
    end
  end

  assign level = flt_level;
`else
  assign level = sync_q1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q    <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      level_q    <= level;
      rise_pulse <= level & ~level_q;
    end
  end

endmodule

// File: rtl/anemo_freq_meter.sv
// Counts anemometer rising edges per gate window (continuous or single-shot); result and valid load
// on the edge ending the window, no backpressure. Optional glitch filter: ANEMO_GLITCH_FILTER_EN.
module anemo_freq_meter
  import anemo_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int GATE_MS     = 1000,
  parameter int FILTER_LEN  = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_freq_anemo,
  input  logic                    continu,
  input  logic                    start_stop,
  output logic [ANEMO_DATA_W-1:0] data_anemo,
  output logic                    data_valid
);

  localparam int GATE_CYCLES = gate_cycles(CLK_FREQ_HZ, GATE_MS);
  localparam int GATE_W      = gate_cnt_w(CLK_FREQ_HZ, GATE_MS);

  if (GATE_CYCLES < 2 || FILTER_LEN < 1) begin : g_bad_cfg
    $error("anemo_freq_meter: GATE_CYCLES must be >= 2 and FILTER_LEN >= 1");
  end

  anemo_state_t            state, state_nxt;
  logic [GATE_W-1:0]       gate_cnt, gate_nxt;
  logic [ANEMO_DATA_W-1:0] edge_cnt, edge_nxt, edge_sum;
  logic [ANEMO_DATA_W-1:0] data_nxt;
  logic                    valid_nxt;
  logic                    continu_q;
  logic                    rise_pulse;
  logic                    win_end;
  logic                    abort;

`ifdef ANEMO_GLITCH_FILTER_EN
  anemo_edge_detect #(.FILTER_LEN(FILTER_LEN)) u_edge (
`else
  anemo_edge_detect u_edge (
`endif
    .clk        (clk),
    .reset_n    (reset_n),
    .raw_pulse  (in_freq_anemo),
    .rise_pulse (rise_pulse)
  );

  // Saturating count including this cycle's edge, so a last-cycle edge lands in the ending window.
  assign edge_sum = (rise_pulse && edge_cnt != ANEMO_DATA_W'(ANEMO_SAT)) ?
                    edge_cnt + ANEMO_DATA_W'(1) : edge_cnt;
  assign win_end  = (gate_cnt == GATE_W'(GATE_CYCLES - 1));
  assign abort    = (continu != continu_q) || (!continu && !start_stop);

  always_comb begin
    state_nxt = state;
    gate_nxt  = gate_cnt;
    edge_nxt  = edge_cnt;
    data_nxt  = data_anemo;
    valid_nxt = data_valid;
    case (state)
      ST_IDLE: begin
        gate_nxt = '0;
        edge_nxt = '0;
        if (continu || start_stop) state_nxt = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (abort) begin
          state_nxt = ST_IDLE;
          gate_nxt  = '0;
          edge_nxt  = '0;
          valid_nxt = 1'b0;
        end else if (win_end) begin
          state_nxt = continu ? ST_MEASURE : ST_DONE;
          gate_nxt  = '0;
          edge_nxt  = '0;
          data_nxt  = edge_sum;
          valid_nxt = 1'b1;
        end else begin
          gate_nxt = gate_cnt + GATE_W'(1);
          edge_nxt = edge_sum;
        end
      end
      ST_DONE: begin
        if (abort) begin
          state_nxt = ST_IDLE;
          valid_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        gate_nxt  = '0;
        edge_nxt  = '0;
        valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      data_anemo <= '0;
      data_valid <= 1'b0;
      continu_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      gate_cnt   <= gate_nxt;
      edge_cnt   <= edge_nxt;
      data_anemo <= data_nxt;
      data_valid <= valid_nxt;
      continu_q  <= continu;
    end
  end

endmodule

// File: tb/tb_anemo_freq_meter.sv
// Bench for anemo_freq_meter: random pulse trains scored per gate window against a rise-time model.
module tb_anemo_freq_meter;

  localparam int G  = 100;
  localparam int GL = 600;
  localparam int FL = 4;
`ifdef ANEMO_GLITCH_FILTER_EN
  localparam int LAT        = 4 + FL;
  localparam int MIN_H      = FL;
  localparam int SAT_EXP    = 0;
  localparam int GLITCH_EXP = 0;
`else
  localparam int LAT        = 4;
  localparam int MIN_H      = 1;
  localparam int SAT_EXP    = 255;
  localparam int GLITCH_EXP = 10;
`endif

  logic       clk;
  logic       reset_n;
  logic       in_freq_anemo;
  logic       continu;
  logic       start_stop;
  logic [7:0] data_anemo;
  logic       data_valid;
  logic [7:0] data_long;
  logic       valid_long;

  anemo_freq_meter #(.CLK_FREQ_HZ(1000), .GATE_MS(100), .FILTER_LEN(FL)) dut (
    .clk(clk), .reset_n(reset_n), .in_freq_anemo(in_freq_anemo), .continu(continu),
    .start_stop(start_stop), .data_anemo(data_anemo), .data_valid(data_valid)
  );

  anemo_freq_meter #(.CLK_FREQ_HZ(1000), .GATE_MS(600), .FILTER_LEN(FL)) dut_long (
    .clk(clk), .reset_n(reset_n), .in_freq_anemo(in_freq_anemo), .continu(continu),
    .start_stop(start_stop), .data_anemo(data_long), .data_valid(valid_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Stimulus pattern and the recorded rise times / high durations of in_freq_anemo.
  bit pat_on;
  int pat_per, pat_hi, pat_ph;
  int rise_t[$];
  int rise_h[$];

  bit win_on, long_on;
  int win_s, win_k, long_s;
  int last_exp;
  int s, hold;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // A rise driven after edge t is counted on edge t+LAT; a window started on edge s covers (s, s+G].
  function automatic int model(input int lo, input int hi);
    int n = 0;
    foreach (rise_t[i])
      if (rise_h[i] >= MIN_H && rise_t[i] + LAT > lo && rise_t[i] + LAT <= hi) n++;
    return (n > 255) ? 255 : n;
  endfunction

  task automatic step();
    logic v;
    v = pat_on && (((cyc + pat_ph) % pat_per) < pat_hi);
    if (v && !in_freq_anemo) begin
      rise_t.push_back(cyc);
      rise_h.push_back(1 << 30);
    end
    if (!v && in_freq_anemo) rise_h[rise_h.size()-1] = cyc - rise_t[rise_t.size()-1];
    in_freq_anemo = v;
    @(posedge clk);
    #1;
    if (win_on) begin
      if (win_k == 0 && cyc == win_s + G - 1) check("valid_before_first_window", data_valid, 0);
      if (cyc == win_s + (win_k + 1) * G) begin
        last_exp = model(win_s + win_k * G, win_s + (win_k + 1) * G);
        check("window_count", data_anemo, last_exp);
        check("window_valid", data_valid, 1);
        win_k++;
      end
    end
    if (long_on && cyc == long_s + GL) begin
      check("long_window_count", data_long, model(long_s, long_s + GL));
      check("long_window_valid", valid_long, 1);
      long_on = 0;
    end
  endtask

  task automatic gap();
    pat_on = 0;
    repeat (8) step();
  endtask

  initial begin
    reset_n = 0; in_freq_anemo = 0; continu = 1; start_stop = 0;
    pat_on = 0; pat_per = 10; pat_hi = 5; pat_ph = 0;
    win_on = 0; long_on = 0; win_s = 0; win_k = 0; long_s = 0; last_exp = 0;
    repeat (3) step();
    check("reset_data", data_anemo, 0);
    check("reset_valid", data_valid, 0);
    check("reset_long_valid", valid_long, 0);

    // Continuous mode from reset release; period-2 pulses saturate the 600-cycle window.
    reset_n = 1;
    win_on = 1; win_s = cyc + 1; win_k = 0;
    long_on = 1; long_s = cyc + 1;
    pat_on = 1; pat_per = 2; pat_hi = 1; pat_ph = 0;
    repeat (GL + 5) step();
    check("saturated_count", data_long, SAT_EXP);

    gap();
    pat_on = 1; pat_per = 10; pat_hi = 5; pat_ph = $urandom_range(0, 9);
    repeat (3 * G) step();
    check("period10_count", data_anemo, 10);

    for (int i = 0; i < 4; i++) begin
      gap();
      pat_per = $urandom_range(8, 30);
      pat_hi  = $urandom_range(4, pat_per - 4);
      pat_ph  = $urandom_range(0, 63);
      pat_on  = 1;
      repeat (G + $urandom_range(0, 60)) step();
    end

    // Dropping continu aborts the running window.
    win_on = 0;
    continu = 0;
    step();
    check("continu_change_valid", data_valid, 0);
    check("continu_change_data_held", data_anemo, last_exp);

    // Single-shot measurements: first with period 20, then a random train.
    for (int i = 0; i < 2; i++) begin
      gap();
      pat_per = (i == 0) ? 20 : $urandom_range(8, 30);
      pat_hi  = (i == 0) ? 10 : $urandom_range(4, pat_per - 4);
      pat_ph  = $urandom_range(0, 63);
      pat_on  = 1;
      repeat (20) step();
      start_stop = 1;
      s = cyc + 1;
      repeat (G + 1) step();
      last_exp = model(s, s + G);
      check("single_count", data_anemo, last_exp);
      check("single_valid", data_valid, 1);
      if (i == 0) check("single_period20", data_anemo, 5);
      hold = $urandom_range(3, 15);
      repeat (hold) step();
      check("single_held_data", data_anemo, last_exp);
      check("single_held_valid", data_valid, 1);
      start_stop = 0;
      step();
      check("single_release_valid", data_valid, 0);
      check("single_release_data", data_anemo, last_exp);
    end

    // Single-shot abort at cycle 50 of the window.
    start_stop = 1;
    repeat (50) step();
    start_stop = 0;
    step();
    check("abort_valid", data_valid, 0);
    repeat (G) step();
    check("abort_no_update", data_anemo, last_exp);
    check("abort_valid_stays_low", data_valid, 0);

    // Reset around cycle 40 of a continuous window.
    continu = 1;
    pat_per = 10; pat_hi = 5; pat_ph = 0; pat_on = 1;
    repeat (34) step();
    gap();
    reset_n = 0;
    #1;
    check("async_reset_data", data_anemo, 0);
    check("async_reset_valid", data_valid, 0);
    repeat (3) step();
    rise_t.delete();
    rise_h.delete();
    reset_n = 1;
    win_on = 1; win_s = cyc + 1; win_k = 0;
    pat_on = 1; pat_ph = $urandom_range(0, 9);
    repeat (G + 1) step();
    check("post_reset_window_seen", win_k, 1);

    // Glitch train, then clean 8-high pulses of period 20.
    gap();
    pat_on = 1; pat_per = 10; pat_hi = 1; pat_ph = $urandom_range(0, 9);
    repeat (3 * G) step();
    check("glitch_count", data_anemo, GLITCH_EXP);
    gap();
    pat_on = 1; pat_per = 20; pat_hi = 8; pat_ph = $urandom_range(0, 19);
    repeat (3 * G) step();
    check("clean_period20_count", data_anemo, 5);
    check("clean_period20_valid", data_valid, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/anemo_freq_meter.md
Name: anemo_freq_meter

Overview:
- Measurement front-end for the anemometer SOPC. Converts the raw anemometer pulse train into an 8-bit wind-speed count, as pulses per gate window.
- Sits directly upstream of the 8-bit Avalon PIO input port. Its data_anemo output drives that port's in_port; data_valid drives a second status PIO bit.
- Supports continuous measurement and single-shot measurement triggered by start_stop.

Parameters:
- CLK_FREQ_HZ, 50000000, system clock frequency in Hz.
- GATE_MS, 1000, gate window length in ms. GATE_CYCLES = CLK_FREQ_HZ/1000*GATE_MS, and must be at least 2.
- FILTER_LEN, 4, number of consecutive identical samples required by the glitch filter (optional feature only).

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, asynchronous, active-low reset.
- in_freq_anemo, in, 1, raw anemometer pulse, asynchronous to clk.
- continu, in, 1, 1 selects continuous mode; 0 selects single-shot mode.
- start_stop, in, 1, single-shot request level; synchronous to clk.
- data_anemo, out, 8, rising-edge count of the last completed window, saturated at 255.
- data_valid, out, 1, 1 when data_anemo holds a completed measurement.

Behaviour:
- Reset is asynchronous, active-low: data_anemo=0, data_valid=0, FSM=IDLE, gate and edge counters=0, synchroniser flops=0.
- in_freq_anemo passes through a 2-flop synchroniser. A rising-edge pulse is generated when the synchronised value goes 0 to 1. Input-to-edge latency is 3 cycles.
- Gate counter runs 0..GATE_CYCLES-1 while in MEASURE. The window ends on the cycle the counter equals GATE_CYCLES-1.
- Edge counter is 8 bits and saturates at 255; it never wraps.
- An edge pulse in the last window cycle counts in the ending window. An edge in the first cycle of the next window counts in the new window.
- End of window: data_anemo loads the final count, including any same-cycle edge, on the next clock edge, and data_valid is set on that same clock edge.
- FSM states:
  - IDLE: counters cleared. Go to MEASURE if continu=1, or if continu=0 and start_stop=1.
  - MEASURE: count edges.
    - At window end with continu=1: latch the result, clear counters, stay in MEASURE (back-to-back windows, no dead cycle).
    - At window end with continu=0: latch the result, go to DONE.
  - DONE (single-shot only): data_valid=1, data_anemo is held. Go to IDLE and clear data_valid when start_stop=0.
- Continuous mode: after the first window, data_valid stays 1 and data_anemo updates every GATE_CYCLES cycles.
- Single-shot mode: dropping start_stop to 0 during MEASURE aborts the window. FSM returns to IDLE, data_valid=0, data_anemo keeps its old value.
- A change of continu in any state aborts the current window. The FSM goes to IDLE, data_valid is cleared, and the next cycle re-enters per the IDLE rules.
- Reset asserted mid-window discards the partial count immediately.

Optional Feature:
- Macro name: ANEMO_GLITCH_FILTER_EN.
- When defined: a filter sits between the synchroniser and the edge detector.
  - The filtered level changes only after the synchronised input has held the new value for FILTER_LEN consecutive cycles.
  - Shorter pulses and glitches are ignored.
  - Input-to-edge latency becomes 3+FILTER_LEN cycles.
  - Filter state resets to 0.
- When undefined: no filter logic, and the synchronised signal feeds the edge detector directly.

Decomposition:
- Package anemo_pkg:
  - FSM state enum (IDLE, MEASURE, DONE).
  - Function returning GATE_CYCLES from CLK_FREQ_HZ and GATE_MS.
  - Function returning the gate counter width as clog2(GATE_CYCLES).
  - Constant ANEMO_DATA_W=8.
  - Constant ANEMO_SAT=255.
- Sub-module anemo_edge_detect: synchroniser, optional filter, and rising-edge pulse output. The top module keeps the FSM, the counters and the output registers.

Test Plan (CLK_FREQ_HZ=1000, GATE_MS=100, so GATE_CYCLES=100, unless noted):
1. continu=1, pulses with 10-cycle period and 5-cycle high time -> data_valid rises at the end of the first window; data_anemo=10 every 100 cycles; no dead cycle between windows.
2. continu=1, GATE_MS=600, pulse period 2 cycles (300 edges per window) -> data_anemo=255, no wrap.
3. continu=0, start_stop 0 then 1, pulse period 20 -> after one window data_anemo=5 and data_valid=1, held while start_stop=1. start_stop=0 -> data_valid=0 next cycle and FSM in IDLE.
4. continu=0, start_stop dropped at cycle 50 of the window -> no update, data_valid=0, data_anemo keeps its previous value.
5. reset_n pulsed low at cycle 40 of a continuous window -> data_anemo=0 and data_valid=0 asynchronously; the first result after release is a full 100-cycle count.
6. With the macro defined (FILTER_LEN=4): 1-cycle glitches every 10 cycles give data_anemo=0, and clean 8-cycle-high pulses with period 20 give data_anemo=5. Without the macro, the same glitches give data_anemo=10.
